// File: rtl/fence_seq_pkg.sv
// ---------------------------------------------------------------------------
// fence_seq_pkg
//   Shared types and helpers for the fence/flush sequencer.
//   - fence_state_e : sequencer FSM states
//   - cnt_width()   : bit width needed to hold values 0..max_value
// ---------------------------------------------------------------------------
package fence_seq_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DRAIN      = 3'd1,
        FLUSH_REQ  = 3'd2,
        FLUSH_WAIT = 3'd3,
        INV_REQ    = 3'd4,
        INV_WAIT   = 3'd5,
        ICACHE     = 3'd6,
        ACK        = 3'd7
    } fence_state_e;

    // Width of a counter that must represent 0..max_value inclusive.
    // A degenerate max of 0 still gets one bit so vectors stay legal.
    function automatic int unsigned cnt_width(input int unsigned max_value);
        if (max_value < 1) begin
            return 1;
        end
        return $clog2(max_value + 1);
    endfunction

endpackage : fence_seq_pkg

// File: rtl/fence_flush_sequencer_store_cnt.sv
// ---------------------------------------------------------------------------
// store_outstanding_cnt
//   Up/down counter of stores issued to the dcache but not yet completed.
//   Saturates at 0 and at MaxCount; an issue while full or a completion while
//   empty is a protocol violation and is flagged by an assertion.
//
// Ports
//   clk_i      in   clock
//   rst_i      in   asynchronous active-high reset (count -> 0)
//   st_issue_i in   store issued (pulse), +1
//   st_done_i  in   store completed (pulse), -1
//   stall_o    out  count == MaxCount, upstream must hold new stores
//   empty_o    out  count == 0
// ---------------------------------------------------------------------------
module store_outstanding_cnt
    import fence_seq_pkg::*;
#(
    parameter int unsigned MaxCount = 7,
    parameter int unsigned Width    = cnt_width(MaxCount)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic st_issue_i,
    input  logic st_done_i,
    output logic stall_o,
    output logic empty_o
);

    localparam logic [Width-1:0] MaxVal = Width'(MaxCount);

    logic [Width-1:0] r_count;
    logic [Width-1:0] w_count_next;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_at_max  = (r_count == MaxVal);
    assign w_at_zero = (r_count == '0);

    // Simultaneous issue and done cancel out. Illegal moves past either
    // bound leave the count where it is instead of wrapping.
    always_comb begin
        w_count_next = r_count;
        if (st_issue_i && !st_done_i && !w_at_max) begin
            w_count_next = r_count + Width'(1);
        end else if (st_done_i && !st_issue_i && !w_at_zero) begin
            w_count_next = r_count - Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign stall_o = w_at_max;
    assign empty_o = w_at_zero;

    a_no_issue_when_full : assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(st_issue_i && !st_done_i && w_at_max)
    ) else $error("store_outstanding_cnt: store issued while counter full");

    a_no_done_when_empty : assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(st_done_i && !st_issue_i && w_at_zero)
    ) else $error("store_outstanding_cnt: store completion while counter empty");

endmodule : store_outstanding_cnt

// File: rtl/fence_flush_sequencer.sv
// ---------------------------------------------------------------------------
// fence_flush_sequencer
//   Executes FENCE / FENCE.I for the controller against a write-back dcache:
//   waits for outstanding stores to drain, optionally writes back (and then
//   optionally invalidates) the dcache, pulses an icache flush for FENCE.I,
//   and finally pulses an acknowledge back to the controller.
//
// Parameters
//   FlushOnFence         1: write back the dcache on every fence
//   InvalidateOnFlush    1: invalidate the dcache after the write-back
//   MaxOutstandingStores capacity of the outstanding-store counter
//   WatchdogCycles       wait cycles after which timeout_o is raised
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   fence_req_i / fence_i_i      fence request (level) and FENCE.I qualifier
//   abort_i                      cancels a fence while still draining stores
//   st_issue_i / st_done_i       store issue / completion pulses
//   st_stall_o                   store counter full
//   dcache_flush_o / _ready_i    write-back request handshake
//   dcache_flush_done_i          write-back complete pulse
//   dcache_inval_o / _ready_i    invalidate request handshake
//   dcache_inval_done_i          invalidate complete pulse
//   icache_flush_o               one-cycle icache flush pulse
//   fence_ack_o                  one-cycle completion pulse
//   busy_o                       sequencer not idle
//   timeout_o                    sticky watchdog flag
// ---------------------------------------------------------------------------
module fence_flush_sequencer
    import fence_seq_pkg::*;
#(
    parameter int unsigned FlushOnFence         = 1,
    parameter int unsigned InvalidateOnFlush    = 0,
    parameter int unsigned MaxOutstandingStores = 7,
    parameter int unsigned WatchdogCycles       = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic fence_req_i,
    input  logic fence_i_i,
    input  logic abort_i,
    input  logic st_issue_i,
    input  logic st_done_i,
    output logic st_stall_o,
    output logic dcache_flush_o,
    input  logic dcache_flush_ready_i,
    input  logic dcache_flush_done_i,
    output logic dcache_inval_o,
    input  logic dcache_inval_ready_i,
    input  logic dcache_inval_done_i,
    output logic icache_flush_o,
    output logic fence_ack_o,
    output logic busy_o,
    output logic timeout_o
);

    localparam bit          FlushEn = (FlushOnFence != 0);
    localparam bit          InvalEn = (InvalidateOnFlush != 0);
    localparam int unsigned WdWidth = cnt_width(WatchdogCycles);
    localparam logic [WdWidth-1:0] WdLimit = WdWidth'(WatchdogCycles);

    // ------------------------------------------------------------------
    // Outstanding store tracking (counts in every state)
    // ------------------------------------------------------------------
    logic w_cnt_empty;
    logic w_cnt_stall;

    store_outstanding_cnt #(
        .MaxCount (MaxOutstandingStores)
    ) u_store_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .st_issue_i (st_issue_i),
        .st_done_i  (st_done_i),
        .stall_o    (w_cnt_stall),
        .empty_o    (w_cnt_empty)
    );

    assign st_stall_o = w_cnt_stall;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    fence_state_e        r_state;
    fence_state_e        w_state_next;
    logic                r_is_fi;
    logic [WdWidth-1:0]  r_wd;
    logic [WdWidth-1:0]  w_wd_inc;
    logic                r_timeout;
    logic                r_flush;
    logic                r_inval;
    logic                r_icache;
    logic                r_ack;
    logic                r_busy;

    logic                w_accept;
    logic                w_wd_active;
    fence_state_e        w_after_dcache;
    fence_state_e        w_after_flush;

    assign w_accept = (r_state == IDLE) && fence_req_i;

    // Where to go once all dcache work is finished: FENCE.I still needs the
    // icache pulse, a plain FENCE goes straight to the acknowledge.
    assign w_after_dcache = r_is_fi ? ICACHE : ACK;
    assign w_after_flush  = InvalEn ? INV_REQ : w_after_dcache;

    // The watchdog only runs while we are waiting on stores or on the cache.
    assign w_wd_active = (r_state == DRAIN)      ||
                         (r_state == FLUSH_REQ)  ||
                         (r_state == FLUSH_WAIT) ||
                         (r_state == INV_REQ)    ||
                         (r_state == INV_WAIT);

    assign w_wd_inc = r_wd + WdWidth'(1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (fence_req_i) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // A store issued this very cycle would land after the
                // flush, so the counter must be empty with no issue pending.
                if (abort_i) begin
                    w_state_next = IDLE;
                end else if (w_cnt_empty && !st_issue_i) begin
                    w_state_next = FlushEn ? FLUSH_REQ : w_after_dcache;
                end
            end
            FLUSH_REQ: begin
                // The cache may accept and finish in the same cycle; the
                // done pulse would be lost if we waited for it in FLUSH_WAIT.
                if (dcache_flush_ready_i) begin
                    w_state_next = dcache_flush_done_i ? w_after_flush : FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (dcache_flush_done_i) begin
                    w_state_next = w_after_flush;
                end
            end
            INV_REQ: begin
                if (dcache_inval_ready_i) begin
                    w_state_next = dcache_inval_done_i ? w_after_dcache : INV_WAIT;
                end
            end
            INV_WAIT: begin
                if (dcache_inval_done_i) begin
                    w_state_next = w_after_dcache;
                end
            end
            ICACHE: begin
                w_state_next = ACK;
            end
            ACK: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one
    // is glitch-free and asserted exactly while the FSM sits in its state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_is_fi   <= 1'b0;
            r_wd      <= '0;
            r_timeout <= 1'b0;
            r_flush   <= 1'b0;
            r_inval   <= 1'b0;
            r_icache  <= 1'b0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_flush  <= (w_state_next == FLUSH_REQ);
            r_inval  <= (w_state_next == INV_REQ);
            r_icache <= (w_state_next == ICACHE);
            r_ack    <= (w_state_next == ACK);
            r_busy   <= (w_state_next != IDLE);

            if (w_accept) begin
                r_is_fi   <= fence_i_i;
                r_wd      <= '0;
                r_timeout <= 1'b0;
            end else if (w_wd_active && (r_wd != WdLimit)) begin
                r_wd <= w_wd_inc;
                if (w_wd_inc == WdLimit) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign dcache_flush_o = r_flush;
    assign dcache_inval_o = r_inval;
    assign icache_flush_o = r_icache;
    assign fence_ack_o    = r_ack;
    assign busy_o         = r_busy;
    assign timeout_o      = r_timeout;

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    a_flush_stable : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (dcache_flush_o && !dcache_flush_ready_i) |=> dcache_flush_o
    ) else $error("fence_flush_sequencer: flush request dropped before ready");

    a_inval_stable : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (dcache_inval_o && !dcache_inval_ready_i) |=> dcache_inval_o
    ) else $error("fence_flush_sequencer: invalidate request dropped before ready");

    a_ack_single : assert property (
        @(posedge clk_i) disable iff (rst_i)
        fence_ack_o |=> !fence_ack_o
    ) else $error("fence_flush_sequencer: acknowledge longer than one cycle");

    a_icache_single : assert property (
        @(posedge clk_i) disable iff (rst_i)
        icache_flush_o |=> !icache_flush_o
    ) else $error("fence_flush_sequencer: icache flush longer than one cycle");

endmodule : fence_flush_sequencer

// File: doc/fence_flush_sequencer.md
Name: fence_flush_sequencer

Overview:
Sequences FENCE/FENCE.I between the controller and the write-back HPDcache subsystem. It tracks outstanding stores, drains them, and issues a dcache write-back flush (and optional invalidate) when DcacheFlushOnFence is set. For FENCE.I it also pulses an icache flush, then acknowledges the controller. It sits directly downstream of the cva6_cfg configuration and upstream of the HPDcache flush/invalidate request port.

Parameters:
- FlushOnFence, 1, 1 = write back the dcache on every fence; 0 = drain stores only.
- InvalidateOnFlush, 0, 1 = issue a dcache invalidate after the write-back completes.
- MaxOutstandingStores, 7, capacity of the outstanding-store counter.
- WatchdogCycles, 4096, cycle threshold that sets timeout_o during waits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- fence_req_i  in  1  controller fence request; level, held until fence_ack_o
- fence_i_i  in  1  qualifies fence_req_i as FENCE.I; sampled on accept
- abort_i  in  1  pipeline flush/exception; honoured only in DRAIN
- st_issue_i  in  1  store issued to dcache (pulse)
- st_done_i  in  1  store completed by dcache (pulse)
- st_stall_o  out  1  counter at MaxOutstandingStores; block new store issue
- dcache_flush_o  out  1  write-back flush request; valid/ready handshake
- dcache_flush_ready_i  in  1  HPDcache accepts the flush request
- dcache_flush_done_i  in  1  HPDcache reports the write-back complete (pulse)
- dcache_inval_o  out  1  invalidate request; same handshake as flush
- dcache_inval_ready_i  in  1  invalidate accepted
- dcache_inval_done_i  in  1  invalidate complete (pulse)
- icache_flush_o  out  1  one-cycle icache flush pulse
- fence_ack_o  out  1  one-cycle completion pulse to the controller
- busy_o  out  1  FSM not in IDLE
- timeout_o  out  1  sticky watchdog flag; cleared on the next accepted fence

Behaviour:
- Reset is asynchronous on rst_i. Reset values: all outputs 0, FSM in IDLE, counters 0.
- Outstanding counter width: $clog2(MaxOutstandingStores+1).
  - +1 on st_issue_i, -1 on st_done_i; both in the same cycle leaves it unchanged.
  - st_stall_o = (count == MaxOutstandingStores), combinational from the register.
  - Issue at max, or done at 0, is illegal: assertion fires and the counter saturates.
- FSM states:
  - IDLE: on fence_req_i, capture fence_i_i into is_fi, clear timeout_o, clear the watchdog, go to DRAIN.
  - DRAIN: when count==0 and no st_issue_i this cycle:
    - go to FLUSH_REQ if FlushOnFence, else to ICACHE if is_fi, else to ACK.
    - abort_i in DRAIN returns to IDLE with no ack. abort_i in any other state is ignored.
  - FLUSH_REQ: dcache_flush_o=1, held stable until dcache_flush_ready_i; on handshake go to FLUSH_WAIT.
  - FLUSH_WAIT: on dcache_flush_done_i go to INV_REQ if InvalidateOnFlush, else to ICACHE/ACK (same rule as DRAIN).
    - A done pulse arriving in FLUSH_REQ in the same cycle as ready is consumed; skip straight past FLUSH_WAIT.
  - INV_REQ / INV_WAIT: mirror FLUSH_REQ / FLUSH_WAIT using the inval signals; then go to ICACHE or ACK.
  - ICACHE: icache_flush_o=1 for exactly one cycle, then go to ACK.
  - ACK: fence_ack_o=1 for one cycle, then go to IDLE. fence_req_i still high in IDLE the next cycle is treated as a new fence.
- Latency: with an empty counter and FlushOnFence=0, FENCE gives ack 2 cycles after accept (DRAIN, ACK).
- Watchdog:
  - Saturating counter, increments in DRAIN and in the *_WAIT / *_REQ states.
  - Sets timeout_o at WatchdogCycles.
  - No state change; report only.
- st_done_i is counted in every state, including during the flush.
- rst_i mid-sequence returns to IDLE immediately. No ack is issued and outstanding requests are dropped; the cache side is reset by the same rst_i.

Decomposition:
- Shared package fence_seq_pkg holds:
  - fence_state_e enum (IDLE, DRAIN, FLUSH_REQ, FLUSH_WAIT, INV_REQ, INV_WAIT, ICACHE, ACK);
  - a function deriving the counter width.
- Parameters are bound at instantiation from cva6_cfg: DcacheFlushOnFence, DcacheInvalidateOnFlush, MaxOutstandingStores.
- One sub-module, store_outstanding_cnt: an up/down saturating counter with stall output and assertions.

Test Plan:
- Plain FENCE, FlushOnFence=0, count=0: fence_req_i at cycle 0 -> fence_ack_o at cycle 2, no flush, no icache pulse.
- FENCE with 3 outstanding stores, completes at cycles 4/6/9, FlushOnFence=1, ready delayed 2 cycles, done 10 cycles after ready:
  - dcache_flush_o rises the cycle after count hits 0 and stays high through ready;
  - ack follows done by 1 cycle.
- FENCE.I with InvalidateOnFlush=1: order is flush handshake -> inval handshake -> one icache_flush_o pulse -> one fence_ack_o pulse; each asserts exactly once.
- Counter boundaries:
  - 7 issues -> st_stall_o=1;
  - simultaneous issue+done at 7 -> stays 7, stall stays 1;
  - done at 0 -> assertion fires, count stays 0.
- abort_i in DRAIN with 2 stores pending -> IDLE, no ack, no flush. abort_i during FLUSH_WAIT -> ignored, ack still issued.
- Watchdog and reset:
  - withhold dcache_flush_done_i for 4096 cycles -> timeout_o=1, FSM still in FLUSH_WAIT;
  - assert rst_i -> all outputs 0 asynchronously, before the next clock edge.
